// File: rtl/ysyx_25040109_axi_pkg.sv
// Shared AXI encodings and crossbar FSM states.
//   RESP_OKAY / RESP_DECERR : response codes driven by the crossbar
//   BURST_INCR / SIZE_4B    : the only burst shape a single-beat-only slave takes
//   rd_state_e / wr_state_e : read and write path state encodings
package ysyx_25040109_axi_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_FWD  = 2'd1,
      RD_ERR  = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_e;
endpackage

// File: rtl/ysyx_25040109_xbar_decode.sv
// Address decoder for one AXI address channel.
//   addr/len/size/burst : request attributes
//   hit  : one-hot target slave (lowest index wins on overlap)
//   idx  : binary index of the hit slave (0 on miss)
//   miss : no slave claims the request
module ysyx_25040109_xbar_decode
   import ysyx_25040109_axi_pkg::*;
#(
   parameter int                 NSLV        = 3,
   parameter logic [NSLV*32-1:0] SLV_BASE    = {32'h10010000, 32'h10000000, 32'h80000000},
   parameter logic [NSLV*32-1:0] SLV_LAST    = {32'h10010007, 32'h10000008, 32'h87ffffff},
   parameter logic [NSLV-1:0]    SIMPLE_MASK = 3'b110,
   localparam int                IDXW        = (NSLV > 1) ? $clog2(NSLV) : 1
) (
   input  logic [31:0]     addr,
   input  logic [7:0]      len,
   input  logic [2:0]      size,
   input  logic [1:0]      burst,
   output logic [NSLV-1:0] hit,
   output logic [IDXW-1:0] idx,
   output logic            miss
);
   logic single;

   // NOTE: every output gets a default before the loop, so no path leaves a
   // value held and no latch is inferred.
   always_comb begin
      single = (len == 8'd0) && (size == SIZE_4B) && (burst == BURST_INCR);
      hit    = '0;
      idx    = '0;
      // Scan downwards so the lowest matching index is the last one written.
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((addr >= SLV_BASE[i*32 +: 32]) && (addr <= SLV_LAST[i*32 +: 32]) &&
             (!SIMPLE_MASK[i] || single)) begin
            hit    = '0;
            hit[i] = 1'b1;
            idx    = IDXW'(i);
         end
      end
      miss = (hit == '0);
   end
endmodule

// File: rtl/ysyx_25040109_axi_xbar_n.sv
// 1-master to NSLV-slave AXI4 crossbar with an internal DECERR responder.
//   in_ar*/in_r*/in_aw*/in_w*/in_b* : upstream master port
//   m_*                             : per-slave valid/ready and response buses,
//                                     broadcast address/data payloads
// Read and write paths are independent, one outstanding transaction each.
module ysyx_25040109_axi_xbar_n
   import ysyx_25040109_axi_pkg::*;
#(
   parameter int                 NSLV        = 3,
   parameter int                 IDW         = 4,
   parameter logic [NSLV*32-1:0] SLV_BASE    = {32'h10010000, 32'h10000000, 32'h80000000},
   parameter logic [NSLV*32-1:0] SLV_LAST    = {32'h10010007, 32'h10000008, 32'h87ffffff},
   parameter logic [NSLV-1:0]    SIMPLE_MASK = 3'b110
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_arvalid,
   input  logic [31:0]         in_araddr,
   input  logic [IDW-1:0]      in_arid,
   input  logic [7:0]          in_arlen,
   input  logic [2:0]          in_arsize,
   input  logic [1:0]          in_arburst,
   output logic                in_arready,
   output logic                in_rvalid,
   output logic [31:0]         in_rdata,
   output logic [1:0]          in_rresp,
   output logic [IDW-1:0]      in_rid,
   output logic                in_rlast,
   input  logic                in_rready,
   input  logic                in_awvalid,
   input  logic [31:0]         in_awaddr,
   input  logic [IDW-1:0]      in_awid,
   input  logic [7:0]          in_awlen,
   input  logic [2:0]          in_awsize,
   input  logic [1:0]          in_awburst,
   output logic                in_awready,
   input  logic                in_wvalid,
   input  logic [31:0]         in_wdata,
   input  logic [3:0]          in_wstrb,
   input  logic                in_wlast,
   output logic                in_wready,
   output logic                in_bvalid,
   output logic [1:0]          in_bresp,
   output logic [IDW-1:0]      in_bid,
   input  logic                in_bready,
   output logic [NSLV-1:0]     m_arvalid,
   input  logic [NSLV-1:0]     m_arready,
   output logic [31:0]         m_araddr,
   output logic [IDW-1:0]      m_arid,
   output logic [7:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [1:0]          m_arburst,
   input  logic [NSLV-1:0]     m_rvalid,
   input  logic [NSLV-1:0]     m_rlast,
   input  logic [NSLV*32-1:0]  m_rdata,
   input  logic [NSLV*2-1:0]   m_rresp,
   input  logic [NSLV*IDW-1:0] m_rid,
   output logic [NSLV-1:0]     m_rready,
   output logic [NSLV-1:0]     m_awvalid,
   input  logic [NSLV-1:0]     m_awready,
   output logic [31:0]         m_awaddr,
   output logic [IDW-1:0]      m_awid,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   output logic [NSLV-1:0]     m_wvalid,
   input  logic [NSLV-1:0]     m_wready,
   output logic [31:0]         m_wdata,
   output logic [3:0]          m_wstrb,
   output logic                m_wlast,
   input  logic [NSLV-1:0]     m_bvalid,
   input  logic [NSLV*2-1:0]   m_bresp,
   input  logic [NSLV*IDW-1:0] m_bid,
   output logic [NSLV-1:0]     m_bready
);
   localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

   logic [NSLV-1:0] ar_hit, aw_hit;
   logic [IDXW-1:0] ar_idx, aw_idx;
   logic            ar_miss, aw_miss;

   ysyx_25040109_xbar_decode #(
      .NSLV(NSLV), .SLV_BASE(SLV_BASE), .SLV_LAST(SLV_LAST), .SIMPLE_MASK(SIMPLE_MASK)
   ) u_ar_dec (
      .addr(in_araddr), .len(in_arlen), .size(in_arsize), .burst(in_arburst),
      .hit(ar_hit), .idx(ar_idx), .miss(ar_miss)
   );

   ysyx_25040109_xbar_decode #(
      .NSLV(NSLV), .SLV_BASE(SLV_BASE), .SLV_LAST(SLV_LAST), .SIMPLE_MASK(SIMPLE_MASK)
   ) u_aw_dec (
      .addr(in_awaddr), .len(in_awlen), .size(in_awsize), .burst(in_awburst),
      .hit(aw_hit), .idx(aw_idx), .miss(aw_miss)
   );

   // Payloads are broadcast; only the per-slave valid selects a target.
   assign m_araddr  = in_araddr;
   assign m_arid    = in_arid;
   assign m_arlen   = in_arlen;
   assign m_arsize  = in_arsize;
   assign m_arburst = in_arburst;
   assign m_awaddr  = in_awaddr;
   assign m_awid    = in_awid;
   assign m_awlen   = in_awlen;
   assign m_awsize  = in_awsize;
   assign m_awburst = in_awburst;
   assign m_wdata   = in_wdata;
   assign m_wstrb   = in_wstrb;
   assign m_wlast   = in_wlast;

   // ---------------- read path ----------------
   rd_state_e       rd_state, rd_next;
   logic [IDXW-1:0] rd_tgt;
   logic [IDW-1:0]  rd_id;
   logic [7:0]      rd_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= RD_IDLE;
         rd_tgt   <= '0;
         rd_id    <= '0;
         rd_cnt   <= '0;
      end else begin
         rd_state <= rd_next;
         if (rd_state == RD_IDLE && in_arvalid && in_arready) begin
            rd_tgt <= ar_idx;
            rd_id  <= in_arid;
            rd_cnt <= in_arlen;
         end else if (rd_state == RD_ERR && in_rready && rd_cnt != 8'd0) begin
            rd_cnt <= rd_cnt - 8'd1;
         end
      end
   end

   always_comb begin
      rd_next    = rd_state;
      in_arready = 1'b0;
      m_arvalid  = '0;
      in_rvalid  = 1'b0;
      in_rdata   = '0;
      in_rresp   = RESP_OKAY;
      in_rid     = '0;
      in_rlast   = 1'b0;
      m_rready   = '0;
      case (rd_state)
         RD_IDLE: begin
            m_arvalid  = ar_hit & {NSLV{in_arvalid}};
            // A miss is swallowed by the internal error responder.
            in_arready = ar_miss | (|(ar_hit & m_arready));
            if (in_arvalid && in_arready) rd_next = ar_miss ? RD_ERR : RD_FWD;
         end
         RD_FWD: begin
            for (int i = 0; i < NSLV; i++) begin
               if (rd_tgt == IDXW'(i)) begin
                  in_rvalid   = m_rvalid[i];
                  in_rdata    = m_rdata[i*32 +: 32];
                  in_rresp    = m_rresp[i*2 +: 2];
                  in_rid      = m_rid[i*IDW +: IDW];
                  in_rlast    = m_rlast[i];
                  m_rready[i] = in_rready;
               end
            end
            if (in_rvalid && in_rready && in_rlast) rd_next = RD_IDLE;
         end
         RD_ERR: begin
            in_rvalid = 1'b1;
            in_rresp  = RESP_DECERR;
            in_rid    = rd_id;
            in_rlast  = (rd_cnt == 8'd0);
            if (in_rready && in_rlast) rd_next = RD_IDLE;
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   // ---------------- write path ----------------
   wr_state_e       wr_state, wr_next;
   logic [IDXW-1:0] wr_tgt;
   logic [IDW-1:0]  wr_id;
   logic            wr_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         wr_tgt   <= '0;
         wr_id    <= '0;
         wr_err   <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (wr_state == WR_IDLE && in_awvalid && in_awready) begin
            wr_tgt <= aw_idx;
            wr_id  <= in_awid;
            wr_err <= aw_miss;
         end
      end
   end

   always_comb begin
      wr_next    = wr_state;
      in_awready = 1'b0;
      m_awvalid  = '0;
      in_wready  = 1'b0;
      m_wvalid   = '0;
      in_bvalid  = 1'b0;
      in_bresp   = RESP_OKAY;
      in_bid     = '0;
      m_bready   = '0;
      case (wr_state)
         WR_IDLE: begin
            m_awvalid  = aw_hit & {NSLV{in_awvalid}};
            in_awready = aw_miss | (|(aw_hit & m_awready));
            if (in_awvalid && in_awready) wr_next = WR_DATA;
         end
         WR_DATA: begin
            if (wr_err) begin
               // Error bursts are drained and discarded.
               in_wready = 1'b1;
            end else begin
               for (int i = 0; i < NSLV; i++) begin
                  if (wr_tgt == IDXW'(i)) begin
                     m_wvalid[i] = in_wvalid;
                     in_wready   = m_wready[i];
                  end
               end
            end
            if (in_wvalid && in_wready && in_wlast) wr_next = WR_RESP;
         end
         WR_RESP: begin
            if (wr_err) begin
               in_bvalid = 1'b1;
               in_bresp  = RESP_DECERR;
               in_bid    = wr_id;
            end else begin
               for (int i = 0; i < NSLV; i++) begin
                  if (wr_tgt == IDXW'(i)) begin
                     in_bvalid   = m_bvalid[i];
                     in_bresp    = m_bresp[i*2 +: 2];
                     in_bid      = m_bid[i*IDW +: IDW];
                     m_bready[i] = in_bready;
                  end
               end
            end
            if (in_bvalid && in_bready) wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ysyx_25040109_axi_xbar_n.sv
// Scoreboard bench for the AXI crossbar: stimulus pushes expected R/B
// responses, a monitor pops and compares on every upstream handshake.
// Bench discipline: drive at posedge+1, sample at negedge.
module tb_ysyx_25040109_axi_xbar_n;
   import ysyx_25040109_axi_pkg::*;

   localparam int NSLV = 3;
   localparam int IDW  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                in_arvalid = 1'b0, in_arready;
   logic [31:0]         in_araddr = '0;
   logic [IDW-1:0]      in_arid = '0;
   logic [7:0]          in_arlen = '0;
   logic [2:0]          in_arsize = 3'b010;
   logic [1:0]          in_arburst = 2'b01;
   logic                in_rvalid, in_rlast;
   logic [31:0]         in_rdata;
   logic [1:0]          in_rresp;
   logic [IDW-1:0]      in_rid;
   logic                in_rready = 1'b1;
   logic                in_awvalid = 1'b0, in_awready;
   logic [31:0]         in_awaddr = '0;
   logic [IDW-1:0]      in_awid = '0;
   logic [7:0]          in_awlen = '0;
   logic [2:0]          in_awsize = 3'b010;
   logic [1:0]          in_awburst = 2'b01;
   logic                in_wvalid = 1'b0, in_wlast = 1'b0, in_wready;
   logic [31:0]         in_wdata = '0;
   logic [3:0]          in_wstrb = '0;
   logic                in_bvalid;
   logic [1:0]          in_bresp;
   logic [IDW-1:0]      in_bid;
   logic                in_bready = 1'b1;
   logic [NSLV-1:0]     m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic [31:0]         m_araddr, m_awaddr, m_wdata;
   logic [IDW-1:0]      m_arid, m_awid;
   logic [7:0]          m_arlen, m_awlen;
   logic [2:0]          m_arsize, m_awsize;
   logic [1:0]          m_arburst, m_awburst;
   logic [NSLV*32-1:0]  m_rdata;
   logic [NSLV*2-1:0]   m_rresp, m_bresp;
   logic [NSLV*IDW-1:0] m_rid, m_bid;
   logic [NSLV-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [3:0]          m_wstrb;
   logic                m_wlast;

   ysyx_25040109_axi_xbar_n dut (
      .clk(clk), .rst(rst),
      .in_arvalid(in_arvalid), .in_araddr(in_araddr), .in_arid(in_arid), .in_arlen(in_arlen),
      .in_arsize(in_arsize), .in_arburst(in_arburst), .in_arready(in_arready),
      .in_rvalid(in_rvalid), .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rid(in_rid),
      .in_rlast(in_rlast), .in_rready(in_rready),
      .in_awvalid(in_awvalid), .in_awaddr(in_awaddr), .in_awid(in_awid), .in_awlen(in_awlen),
      .in_awsize(in_awsize), .in_awburst(in_awburst), .in_awready(in_awready),
      .in_wvalid(in_wvalid), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
      .in_wready(in_wready),
      .in_bvalid(in_bvalid), .in_bresp(in_bresp), .in_bid(in_bid), .in_bready(in_bready),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rid(m_rid), .m_rready(m_rready),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
      .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready)
   );

   typedef struct {
      logic [31:0]    data;
      logic [1:0]     resp;
      logic [IDW-1:0] id;
      logic           last;
   } r_exp_t;

   typedef struct {
      logic [1:0]     resp;
      logic [IDW-1:0] id;
   } b_exp_t;

   r_exp_t r_q[$];
   b_exp_t b_q[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   bit     rnd_stall = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic exp_r(input logic [31:0] d, input logic [1:0] rs, input logic [IDW-1:0] id,
                        input logic l);
      r_exp_t e;
      e.data = d; e.resp = rs; e.id = id; e.last = l;
      r_q.push_back(e);
   endtask

   task automatic exp_b(input logic [1:0] rs, input logic [IDW-1:0] id);
      b_exp_t e;
      e.resp = rs; e.id = id;
      b_q.push_back(e);
   endtask

   // ---------------- slave models ----------------
   logic           s_rbusy[NSLV], s_wbusy[NSLV], s_bpend[NSLV];
   logic [7:0]     s_rlen[NSLV], s_rbeat[NSLV];
   logic [IDW-1:0] s_rid[NSLV], s_bid[NSLV];
   logic [31:0]    s_wdata[NSLV];
   logic [3:0]     s_wstrb[NSLV];
   int             s_wbeats[NSLV];

   // Slave i returns 0xD<i>0000<beat>; slave 2 answers writes with EXOKAY so
   // forwarding of its bresp is visible.
   task automatic drive_slaves();
      for (int i = 0; i < NSLV; i++) begin
         m_arready[i]          = !s_rbusy[i];
         m_rvalid[i]           = s_rbusy[i];
         m_rdata[i*32 +: 32]   = {4'hD, 4'(i), 16'h0000, s_rbeat[i]};
         m_rresp[i*2 +: 2]     = RESP_OKAY;
         m_rid[i*IDW +: IDW]   = s_rid[i];
         m_rlast[i]            = (s_rbeat[i] == s_rlen[i]);
         m_awready[i]          = !s_wbusy[i] && !s_bpend[i];
         m_wready[i]           = s_wbusy[i];
         m_bvalid[i]           = s_bpend[i];
         m_bresp[i*2 +: 2]     = (i == 2) ? 2'b01 : 2'b00;
         m_bid[i*IDW +: IDW]   = s_bid[i];
      end
   endtask

   initial begin
      logic [NSLV-1:0] ar_f, r_f, aw_f, w_f, b_f;
      logic            rst_s, wl_s;
      logic [IDW-1:0]  arid_s, awid_s;
      logic [7:0]      arlen_s;
      logic [31:0]     wd_s;
      logic [3:0]      ws_s;
      for (int i = 0; i < NSLV; i++) begin
         s_rbusy[i] = 0; s_wbusy[i] = 0; s_bpend[i] = 0; s_rlen[i] = 0; s_rbeat[i] = 0;
         s_rid[i] = 0; s_bid[i] = 0; s_wdata[i] = 0; s_wstrb[i] = 0; s_wbeats[i] = 0;
      end
      drive_slaves();
      forever begin
         @(negedge clk);
         rst_s = rst;
         ar_f = m_arvalid & m_arready; r_f = m_rvalid & m_rready;
         aw_f = m_awvalid & m_awready; w_f = m_wvalid & m_wready; b_f = m_bvalid & m_bready;
         arid_s = m_arid; arlen_s = m_arlen; awid_s = m_awid;
         wd_s = m_wdata; ws_s = m_wstrb; wl_s = m_wlast;
         @(posedge clk);
         #1;
         for (int i = 0; i < NSLV; i++) begin
            if (rst_s) begin
               s_rbusy[i] = 0; s_wbusy[i] = 0; s_bpend[i] = 0; s_rbeat[i] = 0; s_rlen[i] = 0;
            end else begin
               if (r_f[i]) begin
                  if (s_rbeat[i] == s_rlen[i]) s_rbusy[i] = 0;
                  else s_rbeat[i] = s_rbeat[i] + 8'd1;
               end
               if (ar_f[i]) begin
                  s_rbusy[i] = 1; s_rid[i] = arid_s; s_rlen[i] = arlen_s; s_rbeat[i] = 0;
               end
               if (b_f[i]) s_bpend[i] = 0;
               if (aw_f[i]) begin
                  s_wbusy[i] = 1; s_bid[i] = awid_s;
               end
               if (w_f[i]) begin
                  s_wdata[i] = wd_s; s_wstrb[i] = ws_s; s_wbeats[i]++;
                  if (wl_s) begin
                     s_wbusy[i] = 0; s_bpend[i] = 1;
                  end
               end
            end
         end
         drive_slaves();
      end
   end

   // ---------------- ready stall generator ----------------
   initial forever begin
      @(posedge clk);
      #1;
      in_rready = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bready = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- monitor ----------------
   initial begin
      r_exp_t re;
      b_exp_t be;
      forever begin
         @(negedge clk);
         if (rst) begin
            r_q.delete();
            b_q.delete();
         end else begin
            if (in_rvalid && in_rready) begin
               if (r_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL r_unexpected: actual rdata=0x%0h required no beat at %0t", in_rdata, $time);
               end else begin
                  re = r_q.pop_front();
                  check("rdata", 64'(in_rdata), 64'(re.data));
                  check("rresp", 64'(in_rresp), 64'(re.resp));
                  check("rid",   64'(in_rid),   64'(re.id));
                  check("rlast", 64'(in_rlast), 64'(re.last));
               end
            end
            if (in_bvalid && in_bready) begin
               if (b_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL b_unexpected: actual bresp=%0d required no response at %0t", in_bresp, $time);
               end else begin
                  be = b_q.pop_front();
                  check("bresp", 64'(in_bresp), 64'(be.resp));
                  check("bid",   64'(in_bid),   64'(be.id));
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ar(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                        input logic [NSLV-1:0] exp_route);
      bit done;
      done = 0;
      in_araddr = addr; in_arid = id; in_arlen = len;
      in_arsize = SIZE_4B; in_arburst = BURST_INCR; in_arvalid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (c == 0) check("ar_route", 64'(m_arvalid), 64'(exp_route));
         done = in_arready;
         tick();
      end
      in_arvalid = 1'b0;
      if (!done) timeout("ar_handshake");
   endtask

   task automatic do_aw(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                        input logic [NSLV-1:0] exp_route);
      bit done;
      done = 0;
      in_awaddr = addr; in_awid = id; in_awlen = len;
      in_awsize = SIZE_4B; in_awburst = BURST_INCR; in_awvalid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (c == 0) check("aw_route", 64'(m_awvalid), 64'(exp_route));
         done = in_awready;
         tick();
      end
      in_awvalid = 1'b0;
      if (!done) timeout("aw_handshake");
   endtask

   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                       input logic [NSLV-1:0] exp_route, output int waits);
      bit done;
      done = 0;
      waits = 0;
      in_wdata = data; in_wstrb = strb; in_wlast = last; in_wvalid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_wready) begin
            check("w_route", 64'(m_wvalid), 64'(exp_route));
            done  = 1;
            waits = c;
         end
         tick();
      end
      in_wvalid = 1'b0;
      in_wlast  = 1'b0;
      if (!done) timeout("w_handshake");
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (r_q.size() == 0 && b_q.size() == 0) return;
      end
      timeout(name);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int waits;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_rvalid",  64'(in_rvalid), 64'(0));
      check("rst_bvalid",  64'(in_bvalid), 64'(0));
      check("rst_wready",  64'(in_wready), 64'(0));
      check("rst_rready",  64'(m_rready),  64'(0));
      check("rst_bready",  64'(m_bready),  64'(0));
      check("rst_wvalid",  64'(m_wvalid),  64'(0));
      check("rst_arvalid", 64'(m_arvalid), 64'(0));
      check("rst_awvalid", 64'(m_awvalid), 64'(0));
      tick();

      // 1: slave0 burst of 4, AR blocked until the last beat
      for (int k = 0; k < 4; k++) exp_r(32'hD000_0000 | 32'(k), 2'b00, 4'h3, k == 3);
      do_ar(32'h8000_0010, 4'h3, 8'd3, 3'b001);
      in_araddr = 32'h0000_0000;   // would be accepted at once in IDLE
      for (int c = 0; c < 40 && r_q.size() != 0; c++) begin
         @(negedge clk);
         if (r_q.size() != 0) check("t1_ar_blocked", 64'(in_arready), 64'(0));
      end
      if (r_q.size() != 0) timeout("t1_drain");
      @(negedge clk);
      check("t1_ar_reopen", 64'(in_arready), 64'(1));
      tick();

      // 2: read miss, 3 DECERR beats
      for (int k = 0; k < 3; k++) exp_r(32'h0, 2'b11, 4'h5, k == 2);
      do_ar(32'h2000_0000, 4'h5, 8'd2, 3'b000);
      wait_drain("t2_drain", 40);
      tick();

      // 3: single-beat-only slave1: burst rejected, single beat routed
      exp_r(32'h0, 2'b11, 4'hA, 1'b0);
      exp_r(32'h0, 2'b11, 4'hA, 1'b1);
      do_ar(32'h1000_0000, 4'hA, 8'd1, 3'b000);
      wait_drain("t3a_drain", 40);
      tick();
      exp_r(32'hD100_0000, 2'b00, 4'hB, 1'b1);
      do_ar(32'h1000_0000, 4'hB, 8'd0, 3'b010);
      wait_drain("t3b_drain", 40);
      tick();

      // 4: write to slave2, W offered before AW must stall
      in_wdata = 32'h0000_1234; in_wstrb = 4'hF; in_wlast = 1'b1; in_wvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t4_w_stall_ready",  64'(in_wready), 64'(0));
         check("t4_w_stall_mvalid", 64'(m_wvalid),  64'(0));
         tick();
      end
      exp_b(2'b01, 4'h9);
      do_aw(32'h1001_0004, 4'h9, 8'd0, 3'b100);
      do_w(32'h0000_1234, 4'hF, 1'b1, 3'b100, waits);
      wait_drain("t4_drain", 40);
      check("t4_slv2_wdata", 64'(s_wdata[2]), 64'h1234);
      check("t4_slv2_wstrb", 64'(s_wstrb[2]), 64'hF);
      check("t4_other_beats", 64'(s_wbeats[0] + s_wbeats[1]), 64'(0));
      tick();

      // 5: write miss, 8 beats drained without stalls, one DECERR B
      exp_b(2'b11, 4'h4);
      do_aw(32'h3000_0000, 4'h4, 8'd7, 3'b000);
      for (int k = 0; k < 8; k++) begin
         do_w(32'hC0 + 32'(k), 4'hF, k == 7, 3'b000, waits);
         check("t5_no_wait", 64'(waits), 64'(0));
      end
      wait_drain("t5_drain", 40);
      tick();

      // 6: concurrent read/write to slave0 under random ready stalls
      rnd_stall = 1'b1;
      for (int k = 0; k < 8; k++) exp_r(32'hD000_0000 | 32'(k), 2'b00, 4'h1, k == 7);
      exp_b(2'b00, 4'h2);
      fork
         do_ar(32'h8000_0100, 4'h1, 8'd7, 3'b001);
         begin
            int wt;
            do_aw(32'h8000_0200, 4'h2, 8'd3, 3'b001);
            for (int k = 0; k < 4; k++) do_w(32'hA0 + 32'(k), 4'hF, k == 3, 3'b001, wt);
         end
      join
      wait_drain("t6_drain", 400);
      check("t6_slv0_beats", 64'(s_wbeats[0]), 64'(4));
      check("t6_slv0_wdata", 64'(s_wdata[0]), 64'hA3);

      // 6b: reset mid-burst abandons the transfer
      for (int k = 0; k < 16; k++) exp_r(32'hD000_0000 | 32'(k), 2'b00, 4'h6, k == 15);
      do_ar(32'h8000_0000, 4'h6, 8'd15, 3'b001);
      repeat (6) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_rvalid",  64'(in_rvalid), 64'(0));
      check("t6_rst_bvalid",  64'(in_bvalid), 64'(0));
      check("t6_rst_wready",  64'(in_wready), 64'(0));
      check("t6_rst_rready",  64'(m_rready),  64'(0));
      check("t6_rst_bready",  64'(m_bready),  64'(0));
      check("t6_rst_wvalid",  64'(m_wvalid),  64'(0));
      check("t6_rst_arvalid", 64'(m_arvalid), 64'(0));
      check("t6_rst_awvalid", 64'(m_awvalid), 64'(0));
      check("t6_rst_flushed", 64'(r_q.size()), 64'(0));
      repeat (5) tick();
      rnd_stall = 1'b0;
      tick();
      exp_r(32'hD000_0000, 2'b00, 4'h7, 1'b1);
      do_ar(32'h8000_0000, 4'h7, 8'd0, 3'b001);
      wait_drain("t6_recover_drain", 40);
      repeat (3) tick();

      check("final_r_q_empty", 64'(r_q.size()), 64'(0));
      check("final_b_q_empty", 64'(b_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
